// File: rtl/instrqextra_feed_if.sv
// Bus bundle between predecode, the extra-data feeder and the per-thread
// instruction-extra queue write port. The master modport is the
// environment side (upstream + queue); the slave modport is the feeder.
`ifndef instrQExtra_width
`define instrQExtra_width 32
`endif

interface instrqextra_feed_if #(
   parameter int DATA_WIDTH = `instrQExtra_width
) ();
   // Upstream packet from predecode
   logic                  in_valid;
   logic                  in_thread;
   logic [3:0]            in_mask;
   logic [DATA_WIDTH-1:0] in_data0;
   logic [DATA_WIDTH-1:0] in_data1;
   logic [DATA_WIDTH-1:0] in_data2;
   logic [DATA_WIDTH-1:0] in_data3;
   logic                  in_stall;

   // Queue write port and its stall inputs
   logic                  fStall;
   logic                  doFStall;
   logic                  write_wen;
   logic                  write_thread;
   logic [4:0]            write_cnt;
   logic [4:0]            write_start;
   logic [DATA_WIDTH-1:0] write_data0;
   logic [DATA_WIDTH-1:0] write_data1;
   logic [DATA_WIDTH-1:0] write_data2;
   logic [DATA_WIDTH-1:0] write_data3;

   modport master (
      output in_valid, in_thread, in_mask, in_data0, in_data1, in_data2, in_data3,
      output fStall, doFStall,
      input  in_stall,
      input  write_wen, write_thread, write_cnt, write_start,
      input  write_data0, write_data1, write_data2, write_data3
   );

   modport slave (
      input  in_valid, in_thread, in_mask, in_data0, in_data1, in_data2, in_data3,
      input  fStall, doFStall,
      output in_stall,
      output write_wen, write_thread, write_cnt, write_start,
      output write_data0, write_data1, write_data2, write_data3
   );
endinterface

// File: rtl/instrqextra_feed.sv
// Write-side feeder for the per-thread instruction-extra queue: a 2-entry
// in-order skid FIFO that encodes each packet's mask as one-hot count and
// one-hot start slot, drains into the queue, and flushes per thread.
`ifndef instrQExtra_width
`define instrQExtra_width 32
`endif

module instrqextra_feed #(
   parameter int DATA_WIDTH = `instrQExtra_width
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               except,
   input  logic               except_thread,
   instrqextra_feed_if.slave  bus,
   output logic               err_mask
);

   typedef struct packed {
      logic                       thread;
      logic [4:0]                 cnt_oh;
      logic [4:0]                 start_oh;
      logic [3:0][DATA_WIDTH-1:0] data;
   } entry_t;

   localparam entry_t ENTRY_RST = '{thread: 1'b0, cnt_oh: 5'b00001,
                                    start_oh: 5'b00001, data: '0};

   logic [1:0] occ_q, occ_d;
   entry_t     e0_q, e0_d;
   entry_t     e1_q, e1_d;
   logic       err_q, err_d;

   entry_t     new_e;
   logic       mask_contig;
   logic       wen, stall, pop, push;
   logic       kill0, kill1, keep0, keep1;

   // Mask encoding: one-hot popcount, one-hot lowest set bit, contiguity.
   always_comb begin
      new_e.thread   = bus.in_thread;
      new_e.data     = {bus.in_data3, bus.in_data2, bus.in_data1, bus.in_data0};
      new_e.cnt_oh   = 5'b00001;
      new_e.start_oh = 5'b00001;
      mask_contig    = 1'b1;
      case (bus.in_mask)
         4'b0001: begin new_e.cnt_oh = 5'b00010; new_e.start_oh = 5'b00001; end
         4'b0010: begin new_e.cnt_oh = 5'b00010; new_e.start_oh = 5'b00010; end
         4'b0011: begin new_e.cnt_oh = 5'b00100; new_e.start_oh = 5'b00001; end
         4'b0100: begin new_e.cnt_oh = 5'b00010; new_e.start_oh = 5'b00100; end
         4'b0101: begin new_e.cnt_oh = 5'b00100; new_e.start_oh = 5'b00001; mask_contig = 1'b0; end
         4'b0110: begin new_e.cnt_oh = 5'b00100; new_e.start_oh = 5'b00010; end
         4'b0111: begin new_e.cnt_oh = 5'b01000; new_e.start_oh = 5'b00001; end
         4'b1000: begin new_e.cnt_oh = 5'b00010; new_e.start_oh = 5'b01000; end
         4'b1001: begin new_e.cnt_oh = 5'b00100; new_e.start_oh = 5'b00001; mask_contig = 1'b0; end
         4'b1010: begin new_e.cnt_oh = 5'b00100; new_e.start_oh = 5'b00010; mask_contig = 1'b0; end
         4'b1011: begin new_e.cnt_oh = 5'b01000; new_e.start_oh = 5'b00001; mask_contig = 1'b0; end
         4'b1100: begin new_e.cnt_oh = 5'b00100; new_e.start_oh = 5'b00100; end
         4'b1101: begin new_e.cnt_oh = 5'b01000; new_e.start_oh = 5'b00001; mask_contig = 1'b0; end
         4'b1110: begin new_e.cnt_oh = 5'b01000; new_e.start_oh = 5'b00010; end
         4'b1111: begin new_e.cnt_oh = 5'b10000; new_e.start_oh = 5'b00001; end
         default: begin new_e.cnt_oh = 5'b00001; new_e.start_oh = 5'b00001; end
      endcase
   end

   // FIFO control: pop/flush decide which entries survive, survivors
   // compact toward the head and an accepted packet lands right behind them.
   always_comb begin
      wen   = (occ_q != 2'd0);
      stall = (occ_q == 2'd2);
      pop   = wen & ~bus.fStall & ~bus.doFStall;
      kill0 = except & wen & (e0_q.thread == except_thread);
      kill1 = except & stall & (e1_q.thread == except_thread);
      keep0 = wen & ~pop & ~kill0;
      keep1 = stall & ~kill1;
      push  = bus.in_valid & ~stall & (bus.in_mask != 4'b0000)
            & ~(except & (bus.in_thread == except_thread));

      e0_d = e0_q;
      e1_d = e1_q;
      if (keep0) begin
         if (!keep1 && push) e1_d = new_e;
      end else if (keep1) begin
         e0_d = e1_q;
         if (push) e1_d = new_e;
      end else if (push) begin
         e0_d = new_e;
      end

      occ_d = {1'b0, keep0} + {1'b0, keep1} + {1'b0, push};
      err_d = err_q | (push & ~mask_contig);
   end

   // State registers; reset empties the FIFO immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q <= 2'd0;
         e0_q  <= ENTRY_RST;
         e1_q  <= ENTRY_RST;
         err_q <= 1'b0;
      end else begin
         occ_q <= occ_d;
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         err_q <= err_d;
      end
   end

   assign bus.in_stall     = stall;
   assign bus.write_wen    = wen;
   assign bus.write_thread = e0_q.thread;
   assign bus.write_cnt    = e0_q.cnt_oh;
   assign bus.write_start  = e0_q.start_oh;
   assign bus.write_data0  = e0_q.data[0];
   assign bus.write_data1  = e0_q.data[1];
   assign bus.write_data2  = e0_q.data[2];
   assign bus.write_data3  = e0_q.data[3];
   assign err_mask         = err_q;

endmodule

// File: tb/tb_instrqextra_feed.sv
// Randomized scoreboard bench for instrqextra_feed. A packet-level queue
// model is updated at each clock edge from the driven stimulus; a separate
// monitor compares the DUT head and status outputs on every falling edge.
module tb_instrqextra_feed;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic except, except_thread;
   logic err_mask;

   instrqextra_feed_if #(.DATA_WIDTH(W)) bus ();

   instrqextra_feed #(.DATA_WIDTH(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .except        (except),
      .except_thread (except_thread),
      .bus           (bus),
      .err_mask      (err_mask)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic              thread;
      int                cnt;
      int                start;
      logic [3:0][W-1:0] d;
   } pkt_t;

   pkt_t mq[$];
   logic m_err;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: whatever the DUT presents must match the model's buffered state.
   always @(negedge clk) begin
      if (!rst) begin
         logic [W-1:0] wd [4];
         wd[0] = bus.write_data0;
         wd[1] = bus.write_data1;
         wd[2] = bus.write_data2;
         wd[3] = bus.write_data3;
         check("write_wen", 64'(bus.write_wen), 64'(mq.size() > 0));
         check("in_stall", 64'(bus.in_stall), 64'(mq.size() == 2));
         check("err_mask", 64'(err_mask), 64'(m_err));
         if (mq.size() > 0 && bus.write_wen) begin
            check("write_thread", 64'(bus.write_thread), 64'(mq[0].thread));
            check("write_cnt", 64'(bus.write_cnt), 64'(32'd1 << mq[0].cnt));
            check("write_start", 64'(bus.write_start), 64'(32'd1 << mq[0].start));
            for (int i = mq[0].start; i < mq[0].start + mq[0].cnt; i++)
               check("write_data", 64'(wd[i]), 64'(mq[0].d[i]));
         end
      end
   end

   // Model step at a clock edge using the values driven during the cycle.
   task automatic model_update();
      bit   full, pop, acc;
      int   c, s;
      pkt_t p;
      pkt_t keep[$];
      full = (mq.size() == 2);
      pop  = (mq.size() > 0) && !bus.fStall && !bus.doFStall;
      acc  = bus.in_valid && !full && (bus.in_mask != 4'b0000)
             && !(except && (except_thread == bus.in_thread));
      if (pop) void'(mq.pop_front());
      if (except) begin
         foreach (mq[i]) if (mq[i].thread != except_thread) keep.push_back(mq[i]);
         mq = keep;
      end
      if (acc) begin
         c = $countones(bus.in_mask);
         s = 0;
         while (!bus.in_mask[s]) s++;
         if (int'(bus.in_mask) != (((1 << c) - 1) << s)) m_err = 1'b1;
         p.thread = bus.in_thread;
         p.cnt    = c;
         p.start  = s;
         p.d      = {bus.in_data3, bus.in_data1 ^ bus.in_data1 ^ bus.in_data2,
                     bus.in_data1, bus.in_data0};
         mq.push_back(p);
      end
   endtask

   // One cycle of stimulus: drive after the edge, then advance the model.
   // mode 0: mask 1111 thread 0; 1: random contiguous; 2: any mask incl. zero.
   task automatic cycle(input int pv, input int pd, input int pf, input int pe, input int mode);
      int c, s;
      bus.doFStall  = ($urandom_range(0, 99) < pd);
      bus.fStall    = ($urandom_range(0, 99) < pf);
      except        = ($urandom_range(0, 99) < pe);
      except_thread = 1'($urandom_range(0, 1));
      bus.in_data0  = $urandom;
      bus.in_data1  = $urandom;
      bus.in_data2  = $urandom;
      bus.in_data3  = $urandom;
      bus.in_valid  = (mq.size() < 2) && ($urandom_range(0, 99) < pv);
      bus.in_thread = (mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if (mode == 0) begin
         bus.in_mask = 4'b1111;
      end else if (mode == 1) begin
         c = $urandom_range(1, 4);
         s = $urandom_range(0, 4 - c);
         bus.in_mask = 4'(((1 << c) - 1) << s);
      end else begin
         bus.in_mask = 4'($urandom_range(0, 15));
      end
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_valid = 1'b0; bus.in_thread = 1'b0; bus.in_mask = 4'b0000;
      bus.in_data0 = '0; bus.in_data1 = '0; bus.in_data2 = '0; bus.in_data3 = '0;
      bus.fStall = 1'b0; bus.doFStall = 1'b0;
      except = 1'b0; except_thread = 1'b0;
   endtask

   task automatic check_reset_outputs();
      check("rst write_wen", 64'(bus.write_wen), 64'd0);
      check("rst in_stall", 64'(bus.in_stall), 64'd0);
      check("rst err_mask", 64'(err_mask), 64'd0);
      check("rst write_cnt", 64'(bus.write_cnt), 64'b00001);
      check("rst write_start", 64'(bus.write_start), 64'b00001);
      check("rst write_thread", 64'(bus.write_thread), 64'd0);
      check("rst write_data", 64'({bus.write_data0, bus.write_data1}), 64'd0);
      check("rst write_data_hi", 64'({bus.write_data2, bus.write_data3}), 64'd0);
   endtask

   initial begin
      int n;
      m_err = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_outputs();

      repeat (8)   cycle(100,   0,  0,  0, 0);  // pass-through stream
      repeat (60)  cycle( 80,  30,  0,  0, 1);  // alignment, light stall
      repeat (60)  cycle( 90,  70,  0,  0, 1);  // doFStall backpressure
      repeat (60)  cycle( 90,   0, 70,  0, 1);  // fStall backpressure
      repeat (100) cycle( 90,  50,  0, 30, 1);  // flushes
      repeat (200) cycle( 80,  30, 20, 15, 2);  // zero and non-contiguous masks

      // Fill the FIFO, then reset asynchronously between edges.
      n = 0;
      while (mq.size() < 2 && n < 30) begin
         cycle(100, 100, 0, 0, 1);
         n++;
      end
      check("fill for reset", 64'(mq.size()), 64'd2);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs();
      mq.delete();
      m_err = 1'b0;
      idle_inputs();
      @(posedge clk);
      #1 rst = 1'b0;
      check_reset_outputs();
      repeat (50)  cycle( 80,  30, 10, 10, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/instrqextra_feed.md
# instrQextra_feed

Write-side feeder for the per-thread instruction-extra queue. Accepts one packet per cycle from predecode: up to four extra-data slots, a contiguous valid mask and a thread id. Buffers packets in a 2-entry in-order skid FIFO and drives the queue's write port: `write_wen`, `write_thread`, one-hot `write_cnt`, one-hot `write_start` and `write_data0..3`. Honours the queue's `doFStall` and the global `fStall`, and flushes a thread's buffered packets on `except`.

## Interface
- `DATA_WIDTH`, default `` `instrQExtra_width ``: width of one extra-data slot.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `except`  in  1  flush request.
- `except_thread`  in  1  thread flushed by `except`.
- `in_valid`  in  1  input packet present; legal only when `in_stall`=0.
- `in_thread`  in  1  packet thread.
- `in_mask`  in  4  slot valid bits; bit i covers `in_data<i>`; must be contiguous.
- `in_data0..in_data3`  in  DATA_WIDTH each  slot payloads.
- `in_stall`  out  1  FIFO full; upstream holds its packet.
- `fStall`  in  1  global front stall; blocks the write.
- `doFStall`  in  1  queue-full indication from the queue; blocks the write.
- `write_wen`  out  1  head packet valid.
- `write_thread`  out  1  head packet thread.
- `write_cnt`  out  5  one-hot entry count; bit n means n entries, n = 1..4.
- `write_start`  out  5  one-hot index of the first valid slot; bits 0..3 used.
- `write_data0..write_data3`  out  DATA_WIDTH each  head slot payloads, unshifted.
- `err_mask`  out  1  sticky flag: a non-contiguous `in_mask` was accepted.

## Operation
- **Accept.** A packet is accepted when `in_valid`=1, `in_stall`=0, `in_mask`!=0 and it is not killed by a same-cycle `except` on its thread.
  - A zero mask is dropped silently.
  - A non-contiguous mask is still accepted, with count = popcount and start = lowest set bit. `err_mask` then sets and holds until `rst`.
- **Stored encoding.** Each accepted packet stores:
  - thread;
  - `cnt_oh` = one-hot of popcount(mask), 1..4;
  - `start_oh` = one-hot of the lowest set bit, 0..3;
  - the four payloads, unmodified. Payloads in masked-off slots are don't-care.
  - Invariant: start + count ≤ 4.
- **FIFO.**
  - 2 entries, head at entry 0, occupancy counter 0..2.
  - Push writes entry[occ − pop].
  - Pop shifts entry1 into entry0.
- **Drain.** Pop = `write_wen` & ~`fStall` & ~`doFStall`; the same expression gates the queue's write enables.
- **Outputs.** `write_*` are driven straight from entry0 registers. `write_wen` = (occ ≥ 1).
- **Flush.** `except` clears every buffered entry whose thread equals `except_thread`, including the head even if it pops that cycle. Surviving entries compact toward the head, preserving order.
  - Entries of the other thread are unaffected. Their pop and push proceed normally in the same cycle.
- **Simultaneous push + pop at occ=2.** Not possible, because `in_stall`=1.
- **Simultaneous push + pop at occ=1.** occ stays 1 and the new packet lands in entry0.
- **Flush + push, same thread.** The push is discarded.
- **Flush + push, other thread.** The push lands after the survivors.

## Timing
- **Reset values.** occ=0, `write_wen`=0, `in_stall`=0, `err_mask`=0. `write_cnt`=5'b00001, `write_start`=5'b00001, `write_thread`=0, data=0.
- **Latency.** An accepted packet appears on `write_*` 1 cycle later if the FIFO was empty or the head popped that cycle. Otherwise it appears 1 cycle after the blocking head pops.
- **`in_stall` timing.** `in_stall` = (occ==2), a registered state decode; no combinational path from `doFStall`/`fStall`.
  - It deasserts the cycle after a pop or a flush reduces occ.
- **Throughput.** 1 packet/cycle with `fStall`=`doFStall`=0.
- **Head stability.** A held head keeps all `write_*` stable until popped or flushed.
- **`rst` mid-operation.** Asserting `rst` empties the FIFO immediately (asynchronously). No partial write is visible on the cycle `rst` deasserts.

## Test plan
1. **Pass-through.** Stream mask 4'b1111, thread 0, 8 cycles, `doFStall`=0 → `write_wen` 1 from cycle 1, `write_cnt`=5'b10000, `write_start`=5'b00001, data in order, `in_stall` never 1.
2. **Alignment.** Mask 4'b1100 → `write_cnt`=5'b00100, `write_start`=5'b00100. Mask 4'b0010 → cnt 5'b00010, start 5'b00010. Mask 0 → no `write_wen`.
3. **Backpressure.**
   - Hold `doFStall`=1 and send 3 packets → occ=2 and `in_stall`=1 after the second; upstream holds the third and the head stays stable.
   - Release `doFStall` → pops 1/cycle, `in_stall` drops next cycle, the third packet is accepted, order is preserved.
   - Repeat with `fStall` → same behaviour.
4. **Flush.** Buffer thread1 packet then thread0 packet with `doFStall`=1; assert `except`, `except_thread`=1, while pushing a thread1 packet → occ=1, head = the thread0 packet, the thread1 push is discarded.
5. **Error flag.** Send mask 4'b0101 → accepted with cnt 5'b00100, start 5'b00001; `err_mask`=1 and it remains 1 until `rst`.
6. **Async reset.** Assert `rst` mid-cycle with occ=2 → `write_wen`=0 and `in_stall`=0 before the next edge; all outputs at reset values.
